video_timing_gen: RTL and testbench
===================================

# video_timing_gen

Parametrised raster timing generator for VGA-class displays, the successor to our fixed 640x480 sync generator. Generates hsync/vsync with configurable porches and polarity, plus a pixel-fetch address stream with 2^S pixel/line replication. Fetch signals run PIPE pixel ticks ahead of the delayed, aligned display-side outputs to hide framebuffer read latency. Sits between the clock-enable divider and the framebuffer reader / RGB output stage.

## Interface
- H_DISPLAY, 640, active pixels per line
- H_FRONT, 16, horizontal front porch, in pixels
- H_SYNC, 96, hsync width, in pixels
- H_BACK, 48, horizontal back porch, in pixels
- V_DISPLAY, 480, active lines
- V_FRONT, 10, vertical front porch, in lines
- V_SYNC, 2, vsync width, in lines
- V_BACK, 33, vertical back porch, in lines
- H_SYNC_POL, 0, 1 = hsync active-high, 0 = active-low
- V_SYNC_POL, 0, same for vsync
- SCALE_SHIFT, 0, replication factor S: each fetched pixel covers 2^S x 2^S screen pixels; S in 0..3
- PIPE, 2, pixel ticks from fetch to display outputs, ≥1
- CNT_W, 11, counter / hpos / vpos width
- ADDR_W, 19, fetch address width
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- pix_en  in  1  pixel-tick enable; all state advances only when high
- fetch_valid  out  1  pixel at the current counter position is active
- fetch_addr  out  ADDR_W  framebuffer word address for the current counter position
- hsync  out  1  delayed, polarity applied
- vsync  out  1  delayed, polarity applied
- display_on  out  1  delayed active-video flag
- hpos  out  CNT_W  delayed horizontal position
- vpos  out  CNT_W  delayed vertical position
- line_start  out  1  one-clk pulse when the delayed hpos becomes 0
- frame_start  out  1  one-clk pulse when delayed (hpos,vpos) becomes (0,0)

## Operation
- H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK. V_TOTAL is defined the same way. Line order: display, front, sync, back.
- Counters h and v:
  - On pix_en, h increments. At h = H_TOTAL-1, h wraps to 0 and v increments.
  - At v = V_TOTAL-1 together with the h wrap, v wraps to 0.
- Reset: h = H_TOTAL-1, v = V_TOTAL-1, so the first pix_en gives (0,0).
- fetch_valid = (h < H_DISPLAY) && (v < V_DISPLAY). It is combinational from the counters.
- fetch_addr:
  - While fetch_valid: (v>>S)*(H_DISPLAY>>S) + (h>>S), modulo 2^ADDR_W.
  - Otherwise it holds its last value.
  - It is forced to 0 whenever (h,v) = (H_TOTAL-1, V_TOTAL-1).
  - Implement incrementally. No multiplier.
- Sync decode:
  - Raw hsync is active for h in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1].
  - Raw vsync is active for v in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1].
  - Output level = raw XNOR POL: asserted level is 1 when POL=1, 0 when POL=0.
- Delay line: {raw hsync, raw vsync, fetch_valid, h, v, h==0, (h,v)==(0,0)} passes through PIPE registers. Each register advances on pix_en only.
- line_start and frame_start are the delayed flags ANDed with pix_en. Each is one clk wide.
- Elaboration error if H_DISPLAY or V_DISPLAY is not divisible by 2^S, if PIPE=0, or if H_TOTAL or V_TOTAL does not fit in CNT_W.

## Timing
- Reset values:
  - hsync = ~H_SYNC_POL, vsync = ~V_SYNC_POL (sync inactive).
  - display_on, line_start, frame_start, fetch_addr = 0.
  - hpos = H_TOTAL-1, vpos = V_TOTAL-1.
  - fetch_valid = 0 (counters are at max).
- Reset is asynchronous. Mid-frame assertion forces all of the above immediately. The first pix_en after release starts a full frame at (0,0).
- Latency: display-side outputs equal the fetch-side values of exactly PIPE pix_en ticks earlier. Cycles with pix_en low are not counted.
- pix_en low: every register holds; pulses are 0.
- pix_en may be high every clk (enable divider of 1) or sparse. Behaviour is identical in pix_en ticks.
- Wrap boundary: at the last tick of a frame, h and v wrap to 0 in the same edge and fetch_addr reloads to 0.

## Structure
- Package video_timing_pkg:
  - mode constants for 640x480@60 (defaults) and 800x600@60 (40/128/88, 1/4/23);
  - functions h_total/v_total and clog2-style width helpers.
- Sub-module video_delay_line: parametrised width x PIPE shift register with enable and async reset value input. Instantiate it once for the packed delayed bus.

## Test plan
- Defaults, pix_en every clk → hsync low for exactly 96 ticks starting at hpos=656; line period 800 ticks; display_on high for 640 ticks per line.
- Defaults → vsync low while vpos is 490–491; frame_start once every 420000 ticks; 307200 fetch_valid ticks per frame; last fetch_addr 307199.
- SCALE_SHIFT=1 → at (h=5,v=3) fetch_addr=322; each address is presented for 2 ticks on 2 consecutive lines; max 76799.
- PIPE=3 → display_on rises exactly 3 pix_en ticks after fetch_valid at frame start; hpos/vpos match the counters 3 ticks earlier.
- pix_en 1-in-4 → outputs change only on clks following pix_en; line period 3200 clk; frame_start is 1 clk wide.
- reset pulsed mid-line at vpos=100 → outputs immediately at reset values; after release, first frame_start after PIPE ticks and fetch_addr restarts at 0.

Source files
------------

// File: rtl/video_timing_pkg.sv
// -----------------------------------------------------------------------------
// video_timing_pkg
//   Shared definitions for the raster timing generator:
//   - video_mode_t and standard mode constants (640x480@60, 800x600@60)
//   - h_total / v_total helpers (sum of display + porches + sync)
//   - bits_for: minimum unsigned width able to hold a value
//   - video_flags_t: single-bit flags carried down the display delay line
// -----------------------------------------------------------------------------
package video_timing_pkg;

    typedef struct packed {
        int h_display;
        int h_front;
        int h_sync;
        int h_back;
        int v_display;
        int v_front;
        int v_sync;
        int v_back;
    } video_mode_t;

    localparam video_mode_t MODE_640X480_60 = '{
        h_display: 640, h_front: 16, h_sync: 96,  h_back: 48,
        v_display: 480, v_front: 10, v_sync: 2,   v_back: 33
    };

    localparam video_mode_t MODE_800X600_60 = '{
        h_display: 800, h_front: 40, h_sync: 128, h_back: 88,
        v_display: 600, v_front: 1,  v_sync: 4,   v_back: 23
    };

    // Flags that travel alongside hpos/vpos through the delay line.
    typedef struct packed {
        logic hsync_raw;    // inside horizontal sync interval
        logic vsync_raw;    // inside vertical sync interval
        logic active;       // fetch_valid at this position
        logic line_first;   // h == 0
        logic frame_first;  // (h, v) == (0, 0)
    } video_flags_t;

    function automatic int h_total(input int display, input int front,
                                   input int sync, input int back);
        return display + front + sync + back;
    endfunction

    function automatic int v_total(input int display, input int front,
                                   input int sync, input int back);
        return display + front + sync + back;
    endfunction

    // Number of bits needed to represent value as an unsigned number.
    function automatic int bits_for(input int value);
        int w;
        w = 1;
        while ((value >> w) != 0) w++;
        return w;
    endfunction

endpackage

// File: rtl/video_delay_line.sv
// -----------------------------------------------------------------------------
// video_delay_line
//   DEPTH-stage shift register of WIDTH-bit words. All stages advance together
//   when en is high and hold otherwise. An asynchronous reset loads every stage
//   with rst_val (expected to be tied to a constant by the parent).
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous, active-high
//   en       in   shift enable
//   rst_val  in   WIDTH  value loaded into every stage on reset
//   d        in   WIDTH  input word
//   q        out  WIDTH  word entered DEPTH enabled shifts earlier
// -----------------------------------------------------------------------------
module video_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = en ? d : stage_q[0];
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = en ? stage_q[i-1] : stage_q[i];
        end
    end

    // NOTE: this is a short register pipeline, not a RAM, so every stage is
    // reset; the display side must read clean inactive values straight after
    // reset, before DEPTH ticks have refilled it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= rst_val;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
//   Parametrised raster timing generator. Horizontal/vertical counters run on
//   pix_en ticks and produce a fetch-side stream (fetch_valid, fetch_addr) with
//   2^SCALE_SHIFT pixel/line replication. Sync/active/position information is
//   delayed PIPE ticks so the display-side outputs line up with pixel data
//   returned by the framebuffer reader.
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high
//   pix_en       in   pixel-tick enable; all state advances only when high
//   fetch_valid  out  current counter position is in the active area
//   fetch_addr   out  ADDR_W framebuffer word address for current position
//   hsync        out  delayed horizontal sync, polarity applied
//   vsync        out  delayed vertical sync, polarity applied
//   display_on   out  delayed active-video flag
//   hpos         out  CNT_W delayed horizontal position
//   vpos         out  CNT_W delayed vertical position
//   line_start   out  one-clk pulse while delayed hpos is 0 and pix_en is high
//   frame_start  out  one-clk pulse while delayed (hpos,vpos) is (0,0) and
//                     pix_en is high
// -----------------------------------------------------------------------------
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_DISPLAY   = MODE_640X480_60.h_display,
    parameter int H_FRONT     = MODE_640X480_60.h_front,
    parameter int H_SYNC      = MODE_640X480_60.h_sync,
    parameter int H_BACK      = MODE_640X480_60.h_back,
    parameter int V_DISPLAY   = MODE_640X480_60.v_display,
    parameter int V_FRONT     = MODE_640X480_60.v_front,
    parameter int V_SYNC      = MODE_640X480_60.v_sync,
    parameter int V_BACK      = MODE_640X480_60.v_back,
    parameter int H_SYNC_POL  = 0,
    parameter int V_SYNC_POL  = 0,
    parameter int SCALE_SHIFT = 0,
    parameter int PIPE        = 2,
    parameter int CNT_W       = 11,
    parameter int ADDR_W      = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_en,
    output logic              fetch_valid,
    output logic [ADDR_W-1:0] fetch_addr,
    output logic              hsync,
    output logic              vsync,
    output logic              display_on,
    output logic [CNT_W-1:0]  hpos,
    output logic [CNT_W-1:0]  vpos,
    output logic              line_start,
    output logic              frame_start
);

    localparam int H_TOTAL = h_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = v_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (SCALE_SHIFT < 0 || SCALE_SHIFT > 3) begin : g_bad_scale
        $error("video_timing_gen: SCALE_SHIFT must be in 0..3");
    end
    if ((H_DISPLAY % (1 << SCALE_SHIFT)) != 0) begin : g_bad_h_div
        $error("video_timing_gen: H_DISPLAY not divisible by 2^SCALE_SHIFT");
    end
    if ((V_DISPLAY % (1 << SCALE_SHIFT)) != 0) begin : g_bad_v_div
        $error("video_timing_gen: V_DISPLAY not divisible by 2^SCALE_SHIFT");
    end
    if (PIPE < 1) begin : g_bad_pipe
        $error("video_timing_gen: PIPE must be at least 1");
    end
    if (bits_for(H_TOTAL) > CNT_W) begin : g_bad_h_width
        $error("video_timing_gen: H_TOTAL does not fit in CNT_W");
    end
    if (bits_for(V_TOTAL) > CNT_W) begin : g_bad_v_width
        $error("video_timing_gen: V_TOTAL does not fit in CNT_W");
    end

    localparam logic [CNT_W-1:0]  H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0]  V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0]  H_ACT     = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0]  V_ACT     = CNT_W'(V_DISPLAY);
    localparam logic [CNT_W-1:0]  HS_FIRST  = CNT_W'(H_DISPLAY + H_FRONT);
    localparam logic [CNT_W-1:0]  HS_LAST   = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0]  VS_FIRST  = CNT_W'(V_DISPLAY + V_FRONT);
    localparam logic [CNT_W-1:0]  VS_LAST   = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    // Low counter bits that select a replicated sub-pixel / sub-line.
    localparam logic [CNT_W-1:0]  SUB_MASK  = CNT_W'((1 << SCALE_SHIFT) - 1);
    // Framebuffer words per fetched row.
    localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(H_DISPLAY >> SCALE_SHIFT);
    localparam logic              H_POL     = H_SYNC_POL[0];
    localparam logic              V_POL     = V_SYNC_POL[0];

    // ------------------------------------------------------------------
    // Counters and incremental fetch address
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  h_q, h_d;
    logic [CNT_W-1:0]  v_q, v_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;   // address of (h=0) on this row
    logic              h_last, v_last, valid_d;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        h_d        = h_q;
        v_d        = v_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        h_last     = (h_q == H_LAST);
        v_last     = (v_q == V_LAST);

        if (pix_en) begin
            if (h_last) begin
                h_d = '0;
                v_d = v_last ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end

            // A new fetched row begins every 2^S lines.
            if (h_last) begin
                if (v_last) begin
                    row_base_d = '0;
                end else if ((v_d & SUB_MASK) == '0) begin
                    row_base_d = row_base_q + STRIDE;
                end
            end
        end

        valid_d = (h_d < H_ACT) && (v_d < V_ACT);

        if (pix_en) begin
            if (h_d == H_LAST && v_d == V_LAST) begin
                addr_d = '0;
            end else if (valid_d) begin
                if (h_d == '0) begin
                    addr_d = row_base_d;
                end else if ((h_d & SUB_MASK) == '0) begin
                    // Step to the next word every 2^S pixels; otherwise the
                    // same word is replicated.
                    addr_d = addr_q + 1'b1;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values computed above, independent of order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_q        <= H_LAST;
            v_q        <= V_LAST;
            row_base_q <= '0;
            addr_q     <= '0;
        end else begin
            h_q        <= h_d;
            v_q        <= v_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
        end
    end

    assign fetch_valid = (h_q < H_ACT) && (v_q < V_ACT);
    assign fetch_addr  = addr_q;

    // ------------------------------------------------------------------
    // Display-side delay line
    // ------------------------------------------------------------------
    typedef struct packed {
        video_flags_t     flags;
        logic [CNT_W-1:0] h;
        logic [CNT_W-1:0] v;
    } dly_bus_t;

    localparam int DLY_W = $bits(dly_bus_t);

    dly_bus_t bus_in, bus_out, bus_rst;

    always_comb begin
        bus_in.flags.hsync_raw   = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
        bus_in.flags.vsync_raw   = (v_q >= VS_FIRST) && (v_q <= VS_LAST);
        bus_in.flags.active      = fetch_valid;
        bus_in.flags.line_first  = (h_q == '0);
        bus_in.flags.frame_first = (h_q == '0) && (v_q == '0);
        bus_in.h                 = h_q;
        bus_in.v                 = v_q;
    end

    // Reset image of the bus matches the counters' reset position.
    always_comb begin
        bus_rst.flags = '0;
        bus_rst.h     = H_LAST;
        bus_rst.v     = V_LAST;
    end

    video_delay_line #(
        .WIDTH (DLY_W),
        .DEPTH (PIPE)
    ) u_delay (
        .clk     (clk),
        .reset   (reset),
        .en      (pix_en),
        .rst_val (bus_rst),
        .d       (bus_in),
        .q       (bus_out)
    );

    // Asserted level equals the polarity bit: raw XNOR POL.
    assign hsync       = ~(bus_out.flags.hsync_raw ^ H_POL);
    assign vsync       = ~(bus_out.flags.vsync_raw ^ V_POL);
    assign display_on  = bus_out.flags.active;
    assign hpos        = bus_out.h;
    assign vpos        = bus_out.v;
    assign line_start  = bus_out.flags.line_first & pix_en;
    assign frame_start = bus_out.flags.frame_first & pix_en;

endmodule

// File: tb/tb_video_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_video_timing_gen
//   Self-checking bench for video_timing_gen using a small raster (24x12 total,
//   16x8 active), 2x replication, PIPE=3 and mixed sync polarity. The reference
//   model derives every expected output from the number of pix_en ticks since
//   reset: position = (ticks - 1) mod frame size, display position lags by PIPE.
// -----------------------------------------------------------------------------
module tb_video_timing_gen;

    localparam int HD = 16, HF = 2, HS = 3, HB = 3;
    localparam int VD = 8,  VF = 1, VS = 2, VB = 1;
    localparam int HT = HD + HF + HS + HB;   // 24
    localparam int VT = VD + VF + VS + VB;   // 12
    localparam int F  = HT * VT;             // 288 ticks per frame
    localparam int S  = 1;
    localparam int P  = 3;
    localparam int CW = 6;
    localparam int AW = 10;
    localparam int HP = 1;
    localparam int VP = 0;

    logic          clk = 1'b0;
    logic          reset;
    logic          pix_en;
    logic          fetch_valid;
    logic [AW-1:0] fetch_addr;
    logic          hsync, vsync, display_on;
    logic [CW-1:0] hpos, vpos;
    logic          line_start, frame_start;

    int vectors     = 0;
    int miscompares = 0;
    int n           = 0;   // pix_en ticks since reset release
    int addr_m      = 0;   // model fetch address

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_DISPLAY (HD), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_DISPLAY (VD), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
        .H_SYNC_POL (HP), .V_SYNC_POL (VP),
        .SCALE_SHIFT (S), .PIPE (P), .CNT_W (CW), .ADDR_W (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pix_en      (pix_en),
        .fetch_valid (fetch_valid),
        .fetch_addr  (fetch_addr),
        .hsync       (hsync),
        .vsync       (vsync),
        .display_on  (display_on),
        .hpos        (hpos),
        .vpos        (vpos),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d (tick %0d)", tag, obs, exp, n);
        end
    endtask

    // Compare every output against the model for the current tick count.
    task automatic check_all();
        int p, h, v, nd, pd, hd, vd;
        logic hs_raw, vs_raw;
        p  = (n + F - 1) % F;
        h  = p % HT;
        v  = p / HT;
        check("fetch_valid", fetch_valid, (h < HD) && (v < VD));
        check("fetch_addr", fetch_addr, addr_m);
        nd = (n >= P) ? n - P : 0;
        pd = (nd + F - 1) % F;
        hd = pd % HT;
        vd = pd / HT;
        hs_raw = (hd >= HD + HF) && (hd < HD + HF + HS);
        vs_raw = (vd >= VD + VF) && (vd < VD + VF + VS);
        check("hpos", hpos, hd);
        check("vpos", vpos, vd);
        check("display_on", display_on, (hd < HD) && (vd < VD));
        check("hsync", hsync, hs_raw ? HP : 1 - HP);
        check("vsync", vsync, vs_raw ? VP : 1 - VP);
        check("line_start", line_start, pix_en && (hd == 0));
        check("frame_start", frame_start, pix_en && (hd == 0) && (vd == 0));
    endtask

    task automatic model_tick();
        int p, h, v;
        n++;
        p = (n + F - 1) % F;
        h = p % HT;
        v = p / HT;
        if (p == F - 1)
            addr_m = 0;
        else if (h < HD && v < VD)
            addr_m = ((v >> S) * (HD >> S) + (h >> S)) % (1 << AW);
    endtask

    task automatic run_cycle(input logic en);
        @(negedge clk);
        pix_en = en;
        #1;
        check_all();
        @(posedge clk);
        if (pix_en) model_tick();
    endtask

    // Asynchronous reset asserted between clock edges; outputs must change
    // immediately, without waiting for a clock.
    task automatic pulse_reset();
        @(negedge clk);
        pix_en = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        n      = 0;
        addr_m = 0;
        check_all();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        pix_en = 1'b0;
        reset  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        logic reached;
        reset  = 1'b1;
        pix_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all();   // reset state
        @(negedge clk);
        reset = 1'b0;

        // pix_en every clk for two full frames plus a margin.
        for (int c = 0; c < 2 * F + 40; c++) run_cycle(1'b1);

        // Run to a mid-line position on an active line, then reset there.
        reached = 1'b0;
        for (int c = 0; c < 2 * F && !reached; c++) begin
            if (hpos == 5 && vpos == 4) reached = 1'b1;
            else run_cycle(1'b1);
        end
        check("reach_mid_line", reached, 1'b1);
        pulse_reset();

        // Sparse enable: one tick every fourth clk.
        for (int c = 0; c < 4 * F + 100; c++) run_cycle(c % 4 == 0);

        // Random enable density with occasional asynchronous resets.
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 699) == 0) pulse_reset();
            else run_cycle($urandom_range(0, 9) < 6);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
